io_burst_control: RTL and testbench

//  Key/switch front-end that builds memory transactions from SW_W-bit switch chunks.

---
 rtl/io_ctrl_pkg.sv | 27 ++
 rtl/io_burst_control_chunk_loader.sv | 59 +++++
 rtl/io_burst_control.sv | 173 +++++++++++++++++
 tb/tb_io_burst_control.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_ctrl_pkg.sv
// Shared types for the key/switch memory-transaction front-end.
// Latency: n/a (types, encodings and a constant function only).
// Backpressure: n/a.
package io_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ADDR  = 4'd1,
        COUNT = 4'd2,
        DATA  = 4'd3,
        REQ   = 4'd4,
        WAIT  = 4'd5,
        SHOW  = 4'd6,
        DONE  = 4'd7
    } st_e;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_FIN   = 2'b11;

    // Number of sw_w-bit chunks needed to cover a width-bit value.
    function automatic int nchunks(input int width, input int sw_w);
        return (width + sw_w - 1) / sw_w;
    endfunction

endpackage

// File: rtl/io_burst_control_chunk_loader.sv
// Register filled one SW_W-bit chunk at a time, LSB chunk first, with optional +1.
// Latency: a chunk or increment is visible one cycle after ld/inc.
// Backpressure: none; ld/inc are single-cycle strobes, clr has priority.
// Ports: clr (sync clear of value and index), ld (store chunk at current index),
//        inc (value+1, wraps modulo 2^W), chunk (switch value), val, last (index is top chunk).
module chunk_loader
    import io_ctrl_pkg::*;
#(
    parameter int W    = 25,
    parameter int SW_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            ld,
    input  logic            inc,
    input  logic [SW_W-1:0] chunk,
    output logic [W-1:0]    val,
    output logic            last
);
    localparam int N  = nchunks(W, SW_W);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0]      val_q, val_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [N*SW_W-1:0] pad;

    assign last = (idx_q == CW'(N - 1));
    assign val  = val_q;

    always_comb begin
        val_d = val_q;
        idx_d = idx_q;
        pad   = (N*SW_W)'(val_q);
        if (clr) begin
            val_d = '0;
            idx_d = '0;
        end else if (ld) begin
            // Write through a chunk-aligned view so the top chunk simply drops
            // the bits that fall above W.
            pad[int'(idx_q)*SW_W +: SW_W] = chunk;
            val_d = pad[W-1:0];
            idx_d = last ? '0 : idx_q + 1'b1;
        end else if (inc) begin
            val_d = val_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            idx_q <= '0;
        end else begin
            val_q <= val_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/io_burst_control.sv
// Key/switch front-end building single or burst memory reads/writes from switch chunks.
// Latency: key1 committing the last chunk (or advancing) raises mem_req on the next edge.
// Backpressure: one outstanding transaction; waits in WAIT for mem_done, keys ignored there.
// Ports: key0_pulse start/abort/ack, key1_pulse commit/advance, sw chunk+mode bit;
//        mem_* req/done memory handshake; display_data, mode_output, io_done, out_state to UI.
module io_burst_control
    import io_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 16,
    parameter int SW_W      = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key0_pulse,
    input  logic              key1_pulse,
    input  logic [SW_W:0]     sw,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic [DATA_W-1:0] display_data,
    output logic [1:0]        mode_output,
    output logic              io_done,
    output logic [3:0]        out_state
);
    localparam int RW = $clog2(MAX_BURST + 1);

    st_e               state_q, state_d;
    logic              we_q, we_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              go_idle, a_ld, a_inc, d_ld;
    logic              a_last, d_last;
    logic [ADDR_W-1:0] addr_val;
    logic [DATA_W-1:0] wdata_val;

    // Entered length: 0 means a single access, anything larger than MAX_BURST saturates.
    function automatic logic [RW-1:0] clamp_len(input logic [SW_W-1:0] v);
        if (v == '0)
            return RW'(1);
        if (int'(v) > MAX_BURST)
            return RW'(MAX_BURST);
        return RW'(v);
    endfunction

    chunk_loader #(.W(ADDR_W), .SW_W(SW_W)) u_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go_idle),
        .ld    (a_ld),
        .inc   (a_inc),
        .chunk (sw[SW_W-1:0]),
        .val   (addr_val),
        .last  (a_last)
    );

    chunk_loader #(.W(DATA_W), .SW_W(SW_W)) u_wdata (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go_idle),
        .ld    (d_ld),
        .inc   (1'b0),
        .chunk (sw[SW_W-1:0]),
        .val   (wdata_val),
        .last  (d_last)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        rem_d   = rem_q;
        rdata_d = rdata_q;
        go_idle = 1'b0;
        a_ld    = 1'b0;
        a_inc   = 1'b0;
        d_ld    = 1'b0;
        unique case (state_q)
            IDLE: if (key0_pulse) begin
                state_d = ADDR;
                we_d    = sw[SW_W];
            end
            ADDR: if (key0_pulse) begin
                go_idle = 1'b1;
            end else if (key1_pulse) begin
                a_ld = 1'b1;
                if (a_last) state_d = COUNT;
            end
            COUNT: if (key0_pulse) begin
                go_idle = 1'b1;
            end else if (key1_pulse) begin
                rem_d   = clamp_len(sw[SW_W-1:0]);
                state_d = we_q ? DATA : REQ;
            end
            DATA: if (key0_pulse) begin
                go_idle = 1'b1;
            end else if (key1_pulse) begin
                d_ld = 1'b1;
                if (d_last) state_d = REQ;
            end
            REQ: state_d = WAIT;
            // Keys are deliberately ignored here: the transaction must finish.
            WAIT: if (mem_done) begin
                rem_d = rem_q - 1'b1;
                if (!we_q) begin
                    rdata_d = mem_rdata;
                    state_d = SHOW;
                end else if (rem_q == RW'(1)) begin
                    state_d = DONE;
                end else begin
                    a_inc   = 1'b1;
                    state_d = DATA;
                end
            end
            SHOW: if (key0_pulse) begin
                go_idle = 1'b1;
            end else if (key1_pulse) begin
                if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    a_inc   = 1'b1;
                    state_d = REQ;
                end
            end
            DONE: if (key0_pulse) go_idle = 1'b1;
            default: go_idle = 1'b1;
        endcase

        // Any return to IDLE leaves every register as it was out of reset.
        if (go_idle) begin
            state_d = IDLE;
            we_d    = 1'b0;
            rem_d   = '0;
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            rem_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            rem_q   <= rem_d;
            rdata_q <= rdata_d;
        end
    end

    // Decoded straight from the state flop so reset removes a pending request at once.
    assign mem_req      = (state_q == REQ);
    assign mem_we       = mem_req & we_q;
    assign mem_addr     = addr_val;
    assign mem_wdata    = wdata_val;
    assign display_data = we_q ? wdata_val : rdata_q;
    assign io_done      = (state_q == DONE);
    assign out_state    = state_q;

    always_comb begin
        mode_output = we_q ? MODE_WRITE : MODE_READ;
        if (state_q == IDLE)
            mode_output = MODE_IDLE;
        else if (state_q == DONE)
            mode_output = MODE_FIN;
    end

endmodule

// File: tb/tb_io_burst_control.sv
module tb_io_burst_control;
    import io_ctrl_pkg::*;

    typedef struct packed {
        logic        we;
        logic [24:0] addr;
        logic [15:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key0_pulse = 1'b0;
    logic        key1_pulse = 1'b0;
    logic [8:0]  sw = '0;
    logic        mem_req, mem_we;
    logic [24:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_done = 1'b0;
    logic [15:0] display_data;
    logic [1:0]  mode_output;
    logic        io_done;
    logic [3:0]  out_state;

    int          n_checks = 0;
    int          n_pass = 0;
    req_t        exp_q[$];
    logic [24:0] cur_addr = '0;
    logic        resp_en = 1'b1;
    logic [15:0] rd_last = '0;
    logic [15:0] wdat_tbl[16];

    io_burst_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key0_pulse   (key0_pulse),
        .key1_pulse   (key1_pulse),
        .sw           (sw),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_done     (mem_done),
        .display_data (display_data),
        .mode_output  (mode_output),
        .io_done      (io_done),
        .out_state    (out_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Scoreboard monitor: every request the DUT issues is matched against the model queue.
    always @(negedge clk) begin
        if (mem_req) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 32'(mem_req), 32'(0));
            end else begin
                req_t e;
                e = exp_q.pop_front();
                cur_addr = e.addr;
                chk("req_we", 32'(mem_we), 32'(e.we));
                chk("req_addr", 32'(mem_addr), 32'(e.addr));
                if (e.we) chk("req_wdata", 32'(mem_wdata), 32'(e.wdata));
            end
        end else if (out_state == 4'(WAIT)) begin
            chk("addr_stable", 32'(mem_addr), 32'(cur_addr));
        end
    end

    // Memory-controller model: answers each request after 1..3 cycles with random data.
    always begin
        @(negedge clk);
        if (resp_en && mem_req) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rd_last   = 16'($urandom);
            mem_rdata = rd_last;
            mem_done  = 1'b1;
            @(negedge clk);
            mem_done  = 1'b0;
            mem_rdata = 16'($urandom);
        end
    end

    task automatic press(input logic k0, input logic k1, input logic [8:0] s);
        sw = s;
        key0_pulse = k0;
        key1_pulse = k1;
        @(negedge clk);
        key0_pulse = 1'b0;
        key1_pulse = 1'b0;
    endtask

    task automatic wait_st(input logic [3:0] tgt, input string nm);
        int n = 0;
        while (out_state != tgt && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(out_state), 32'(tgt));
    endtask

    // key0 with mode, then the four address chunks; the top chunk carries junk above bit 0.
    task automatic start(input logic we, input logic [24:0] addr);
        logic [31:0] a32;
        a32 = {7'b0, addr};
        press(1'b1, 1'b0, {we, 8'h00});
        chk("mode_out_run", 32'(mode_output), we ? 32'(2) : 32'(1));
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1, {1'b0, 8'(a32 >> (8 * i))});
        press(1'b0, 1'b1, {1'b0, 7'($urandom), a32[24]});
        chk("in_count", 32'(out_state), 32'(COUNT));
    endtask

    task automatic run_txn(input logic we, input logic [24:0] addr, input logic [7:0] len_raw);
        int n;
        n = (len_raw == 0) ? 1 : ((int'(len_raw) > 16) ? 16 : int'(len_raw));
        start(we, addr);
        if (!we) begin
            exp_q.push_back('{we: 1'b0, addr: addr, wdata: 16'h0});
            press(1'b0, 1'b1, {1'b0, len_raw});
            for (int k = 0; k < n; k++) begin
                wait_st(4'(SHOW), "reach_show");
                chk("rd_display", 32'(display_data), 32'(rd_last));
                if (k < n - 1) exp_q.push_back('{we: 1'b0, addr: addr + 25'(k + 1), wdata: 16'h0});
                press(1'b0, 1'b1, 9'h000);
            end
        end else begin
            press(1'b0, 1'b1, {1'b0, len_raw});
            chk("in_data", 32'(out_state), 32'(DATA));
            for (int k = 0; k < n; k++) begin
                exp_q.push_back('{we: 1'b1, addr: addr + 25'(k), wdata: wdat_tbl[k]});
                press(1'b0, 1'b1, {1'b0, wdat_tbl[k][7:0]});
                press(1'b0, 1'b1, {1'b0, wdat_tbl[k][15:8]});
                chk("wr_display", 32'(display_data), 32'(wdat_tbl[k]));
                wait_st((k == n - 1) ? 4'(DONE) : 4'(DATA), "wr_next");
            end
        end
        wait_st(4'(DONE), "reach_done");
        chk("io_done", 32'(io_done), 32'(1));
        chk("mode_fin", 32'(mode_output), 32'(3));
        chk("all_reqs_seen", 32'(exp_q.size()), 32'(0));
        press(1'b1, 1'b0, 9'h000);
        chk("back_idle", 32'(out_state), 32'(IDLE));
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_state"}, 32'(out_state), 32'(IDLE));
        chk({nm, "_req"}, 32'(mem_req), 32'(0));
        chk({nm, "_we"}, 32'(mem_we), 32'(0));
        chk({nm, "_addr"}, 32'(mem_addr), 32'(0));
        chk({nm, "_wdata"}, 32'(mem_wdata), 32'(0));
        chk({nm, "_disp"}, 32'(display_data), 32'(0));
        chk({nm, "_mode"}, 32'(mode_output), 32'(0));
        chk({nm, "_done"}, 32'(io_done), 32'(0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single read at the top address.
        run_txn(1'b0, 25'h1FFFFFF, 8'h01);

        // Write burst of three with fixed data.
        wdat_tbl[0] = 16'hCC33; wdat_tbl[1] = 16'h1234; wdat_tbl[2] = 16'hBEEF;
        run_txn(1'b1, 25'h0000010, 8'h03);

        // Address wrap, zero length, clamped length.
        run_txn(1'b0, 25'h1FFFFFF, 8'h02);
        run_txn(1'b0, 25'h0ABCDEF, 8'h00);
        run_txn(1'b0, 25'h1FFFFF8, 8'hFF);
        for (int i = 0; i < 16; i++) wdat_tbl[i] = 16'($urandom);
        run_txn(1'b1, 25'h1FFFFFE, 8'h11);

        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) wdat_tbl[i] = 16'($urandom);
            run_txn(1'($urandom), 25'($urandom), 8'($urandom_range(0, 20)));
        end

        // Abort while entering data: no request may appear.
        start(1'b1, 25'h0000123);
        press(1'b0, 1'b1, 9'h002);
        press(1'b0, 1'b1, 9'h055);
        press(1'b1, 1'b0, 9'h000);
        chk("abort_data_state", 32'(out_state), 32'(IDLE));
        chk("abort_data_mode", 32'(mode_output), 32'(0));
        chk("abort_data_addr", 32'(mem_addr), 32'(0));
        repeat (3) @(negedge clk);

        // key0 and key1 together in ADDR.
        press(1'b1, 1'b0, 9'h000);
        press(1'b1, 1'b1, 9'h012);
        chk("both_keys_state", 32'(out_state), 32'(IDLE));

        // mem_done in the REQ cycle and key0 in WAIT are both ignored.
        resp_en = 1'b0;
        start(1'b0, 25'h0000444);
        exp_q.push_back('{we: 1'b0, addr: 25'h0000444, wdata: 16'h0});
        press(1'b0, 1'b1, 9'h001);
        mem_rdata = 16'h1234; mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        chk("done_in_req_ignored", 32'(out_state), 32'(WAIT));
        press(1'b1, 1'b0, 9'h000);
        chk("key0_in_wait", 32'(out_state), 32'(WAIT));
        mem_rdata = 16'h5A5A; mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        chk("manual_show", 32'(out_state), 32'(SHOW));
        chk("manual_rdata", 32'(display_data), 32'h5A5A);
        press(1'b0, 1'b1, 9'h000);
        chk("manual_done", 32'(io_done), 32'(1));
        press(1'b1, 1'b0, 9'h000);

        // Reset while waiting on memory; a late mem_done must not revive anything.
        start(1'b1, 25'h0000777);
        press(1'b0, 1'b1, 9'h001);
        exp_q.push_back('{we: 1'b1, addr: 25'h0000777, wdata: 16'hA55A});
        press(1'b0, 1'b1, 9'h05A);
        press(1'b0, 1'b1, 9'h0A5);
        @(negedge clk);
        chk("pre_reset_wait", 32'(out_state), 32'(WAIT));
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        mem_done = 1'b1;
        @(negedge clk);
        mem_done = 1'b0;
        @(negedge clk);
        chk_all_zero("late_done");
        chk("queue_empty_end", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
